// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word fall-through FIFO with a valid/ready stream; 8E1 when UART_RX_PARITY_EN is defined.
// Byte valid 1 clk after the stop-bit sample; consumer stalls via data_ready, and a byte arriving to a full FIFO is dropped with overrun.
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          rxd,
   output logic [7:0]                    data_out,
   output logic                          data_valid,
   input  logic                          data_ready,
   output logic                          framing_err,
   output logic                          overrun,
`ifdef UART_RX_PARITY_EN
   output logic                          parity_err,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int DIV_RAW = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int LW      = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   logic          r_rx_meta;
   logic          r_rxs;
   logic          r_rxs_prev;
   logic [1:0]    r_sync_vld;
   logic          r_armed;

   logic [DW-1:0] r_div_cnt;
   logic          w_tick;

   state_t        r_state;
   logic [3:0]    r_tick_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_framing_err;
`ifdef UART_RX_PARITY_EN
   logic          r_par_bad;
   logic          r_parity_err;
`endif

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          r_overrun;

   logic          w_fall;
   logic          w_start;
   logic          w_stop_sample;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_wr;

   // r_sync_vld marks when r_rxs reflects the real line rather than its reset value,
   // so a line held low across reset release never arms the start detector.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_meta  <= 1'b1;
         r_rxs      <= 1'b1;
         r_rxs_prev <= 1'b1;
         r_sync_vld <= 2'b00;
         r_armed    <= 1'b0;
      end else begin
         r_rx_meta  <= rxd;
         r_rxs      <= r_rx_meta;
         r_rxs_prev <= r_rxs;
         r_sync_vld <= {r_sync_vld[0], 1'b1};
         r_armed    <= r_armed | (r_sync_vld[1] & r_rxs);
      end
   end

   assign w_fall  = r_armed & r_rxs_prev & ~r_rxs;
   assign w_start = (r_state == S_IDLE) && w_fall;
   assign w_tick  = (r_div_cnt == DW'(DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div_cnt <= '0;
      end else if (w_start || w_tick) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_tick_cnt    <= 4'd0;
         r_bit_idx     <= 3'd0;
         r_shift       <= 8'h00;
         r_framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad     <= 1'b0;
         r_parity_err  <= 1'b0;
`endif
      end else begin
         r_framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err  <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_state    <= S_START;
                  r_tick_cnt <= 4'd0;
               end
            end
            S_START: begin
               if (w_tick) begin
                  if (r_tick_cnt == 4'd7) begin
                     r_tick_cnt <= 4'd0;
                     r_bit_idx  <= 3'd0;
                     r_state    <= r_rxs ? S_IDLE : S_DATA;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  if (r_tick_cnt == 4'd15) begin
                     r_tick_cnt         <= 4'd0;
                     r_shift[r_bit_idx] <= r_rxs;
                     if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        r_state <= S_PARITY;
`else
                        r_state <= S_STOP;
`endif
                     end else begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 4'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (w_tick) begin
                  if (r_tick_cnt == 4'd15) begin
                     r_tick_cnt <= 4'd0;
                     r_par_bad  <= (r_rxs != ^r_shift);
                     r_state    <= S_STOP;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 4'd1;
                  end
               end
            end
`endif
            S_STOP: begin
               if (w_tick) begin
                  if (r_tick_cnt == 4'd15) begin
                     r_tick_cnt <= 4'd0;
                     if (!r_rxs) begin
                        r_framing_err <= 1'b1;
                        r_state       <= S_WAIT_HIGH;
                     end else begin
`ifdef UART_RX_PARITY_EN
                        r_parity_err  <= r_par_bad;
`endif
                        r_state       <= S_IDLE;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 4'd1;
                  end
               end
            end
            S_WAIT_HIGH: begin
               if (r_rxs) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_stop_sample = (r_state == S_STOP) && w_tick && (r_tick_cnt == 4'd15);
`ifdef UART_RX_PARITY_EN
   assign w_push = w_stop_sample && r_rxs && !r_par_bad;
`else
   assign w_push = w_stop_sample && r_rxs;
`endif

   assign w_pop  = data_valid && data_ready;
   assign w_full = (r_level == LW'(FIFO_DEPTH));
   // A pop in the same cycle frees the slot, so full + push + pop still writes.
   assign w_wr   = w_push && (!w_full || w_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= 8'h00;
         end
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= w_push && w_full && !w_pop;
         if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign data_out    = r_mem[r_rd_ptr];
   assign data_valid  = (r_level != '0);
   assign fifo_level  = r_level;
   assign framing_err = r_framing_err;
   assign overrun     = r_overrun;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized bench for uart_rx_fifo at 16 clk/bit; a queue model predicts received bytes and overruns.
module tb_uart_rx_fifo;

   localparam int CF  = 1600000;
   localparam int BD  = 100000;
   localparam int DEP = 4;
   localparam int BIT = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rxd;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;
   logic       framing_err;
   logic       overrun;
   logic [2:0] fifo_level;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
   int         pe_cnt = 0;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;
   int vld_cnt  = 0;
   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   logic [7:0] mq[$];
   int exp_ov;

   uart_rx_fifo #(.CLK_FREQ(CF), .BAUD(BD), .FIFO_DEPTH(DEP)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rxd         (rxd),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .framing_err (framing_err),
      .overrun     (overrun),
`ifdef UART_RX_PARITY_EN
      .parity_err  (parity_err),
`endif
      .fifo_level  (fifo_level)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset_n) begin
         if (data_valid && data_ready) got.push_back(data_out);
         if (data_valid) vld_cnt++;
         if (framing_err) fe_cnt++;
         if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
         if (parity_err) pe_cnt++;
`endif
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      rxd = v;
      clks(BIT);
   endtask

   task automatic send(input logic [7:0] b, input logic stop_b, input logic par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^b) ^ par_flip);
`else
      if (par_flip) rxd = 1'b1;
`endif
      drive_bit(stop_b);
   endtask

   initial begin
      logic [7:0] b;
      int         rdy;
      int         gap;

      reset_n    = 1'b0;
      rxd        = 1'b1;
      data_ready = 1'b0;
      clks(4);
      check("rst_data_out", data_out, 8'h00);
      check("rst_valid", data_valid, 1'b0);
      check("rst_ferr", framing_err, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_level", fifo_level, 3'd0);
      reset_n = 1'b1;
      clks(10);

      // single byte, consumer always ready
      data_ready = 1'b1;
      got.delete(); vld_cnt = 0;
      send(8'hA5, 1'b1, 1'b0);
      clks(20);
      check("single_count", got.size(), 1);
      if (got.size() > 0) check("single_data", got[0], 8'hA5);
      check("single_vld_cycles", vld_cnt, 1);
      check("single_ferr", fe_cnt, 0);
      check("single_ovr", ov_cnt, 0);
      check("single_level", fifo_level, 3'd0);

      // back-to-back frames with backpressure
      data_ready = 1'b0;
      got.delete();
      send(8'h01, 1'b1, 1'b0);
      check("b2b_level1", fifo_level, 3'd1);
      send(8'h02, 1'b1, 1'b0);
      send(8'h03, 1'b1, 1'b0);
      send(8'h04, 1'b1, 1'b0);
      clks(20);
      check("b2b_level4", fifo_level, 3'd4);
      check("b2b_head", data_out, 8'h01);
      check("b2b_valid", data_valid, 1'b1);

      // overrun on full FIFO
      send(8'h55, 1'b1, 1'b0);
      clks(20);
      check("ovr_pulses", ov_cnt, 1);
      check("ovr_level", fifo_level, 3'd4);
      check("ovr_head", data_out, 8'h01);

      // drain while the next byte arrives
      data_ready = 1'b1;
      send(8'h66, 1'b1, 1'b0);
      clks(20);
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h66};
      check("drain_count", got.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < got.size()) check($sformatf("drain_%0d", i), got[i], exp_q[i]);
      end
      check("drain_ovr", ov_cnt, 1);
      check("drain_valid", data_valid, 1'b0);
      check("drain_level", fifo_level, 3'd0);

      // short glitch is rejected silently
      got.delete();
      rxd = 1'b0;
      clks(5);
      rxd = 1'b1;
      clks(40);
      check("glitch_bytes", got.size(), 0);
      check("glitch_ferr", fe_cnt, 0);

      // framing error then break: one pulse, nothing pushed
      send(8'h3C, 1'b0, 1'b0);
      clks(64);
      rxd = 1'b1;
      clks(20);
      check("brk_ferr", fe_cnt, 1);
      check("brk_bytes", got.size(), 0);
      check("brk_level", fifo_level, 3'd0);
      send(8'h7E, 1'b1, 1'b0);
      clks(20);
      check("after_brk_count", got.size(), 1);
      if (got.size() > 0) check("after_brk_data", got[0], 8'h7E);

      // reset during bit 4 of 0xF0
      got.delete();
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b0);
      rxd = 1'b1;
      clks(8);
      reset_n = 1'b0;
      #1;
      check("midrst_data_out", data_out, 8'h00);
      check("midrst_valid", data_valid, 1'b0);
      check("midrst_level", fifo_level, 3'd0);
      check("midrst_ferr", framing_err, 1'b0);
      check("midrst_ovr", overrun, 1'b0);
      clks(3);
      reset_n = 1'b1;
      clks(40);

      // line held low across reset release must not start a frame
      reset_n = 1'b0;
      rxd     = 1'b0;
      clks(3);
      reset_n = 1'b1;
      clks(200);
      rxd = 1'b1;
      clks(40);
      check("lowrel_ferr", fe_cnt, 1);
      check("lowrel_bytes", got.size(), 0);
      send(8'h81, 1'b1, 1'b0);
      clks(20);
      check("post_rst_count", got.size(), 1);
      if (got.size() > 0) check("post_rst_data", got[0], 8'h81);

`ifdef UART_RX_PARITY_EN
      got.delete();
      send(8'hA5, 1'b1, 1'b0);
      clks(20);
      check("par_ok_count", got.size(), 1);
      check("par_ok_perr", pe_cnt, 0);
      send(8'hA5, 1'b1, 1'b1);
      clks(20);
      check("par_bad_perr", pe_cnt, 1);
      check("par_bad_count", got.size(), 1);
      check("par_bad_level", fifo_level, 3'd0);
      check("par_bad_ferr", fe_cnt, 1);
`endif

      // randomized frames against a capacity-limited queue model
      got.delete(); exp_q.delete(); mq.delete();
      exp_ov = ov_cnt;
      for (int n = 0; n < 16; n++) begin
         b   = 8'($urandom);
         rdy = $urandom_range(0, 1);
         gap = $urandom_range(0, 24);
         data_ready = rdy[0];
         if (rdy != 0) begin
            while (mq.size() > 0) exp_q.push_back(mq.pop_front());
            exp_q.push_back(b);
         end else if (mq.size() < DEP) begin
            mq.push_back(b);
         end else begin
            exp_ov++;
         end
         send(b, 1'b1, 1'b0);
         rxd = 1'b1;
         if (gap > 0) clks(gap);
      end
      data_ready = 1'b1;
      clks(30);
      while (mq.size() > 0) exp_q.push_back(mq.pop_front());
      check("rand_count", got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got.size()) check($sformatf("rand_byte_%0d", i), got[i], exp_q[i]);
      end
      check("rand_ovr", ov_cnt, exp_ov);
      check("rand_ferr", fe_cnt, 1);
      check("rand_valid_end", data_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receiver for the game board's RS232 link, for the opponent/PC move channel.
- Decodes 8N1 asynchronous frames arriving on UART_RXD, 8 data bits, LSB first.
- Buffers received bytes in a small FIFO and presents them on a valid/ready stream to the game logic.
- It is the receive end of the frames the Computer_System serial port transmits on UART_TXD.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- FIFO_DEPTH, 4, receive buffer entries; must be a power of 2, minimum 2.

Ports:
- clk, input, 1, system clock (CLOCK_50).
- reset_n, input, 1, asynchronous active-low reset.
- rxd, input, 1, serial line; idle high; asynchronous to clk.
- data_out, output, 8, byte at the FIFO head.
- data_valid, output, 1, FIFO not empty.
- data_ready, input, 1, consumer accepts data_out this cycle.
- framing_err, output, 1, one-cycle pulse when a stop bit samples low.
- overrun, output, 1, one-cycle pulse when a byte is dropped because the FIFO is full.
- fifo_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset values:
  - data_out=0, data_valid=0, framing_err=0, overrun=0, fifo_level=0.
  - FSM in IDLE, FIFO pointers 0.
  - Synchroniser flops set to 1 (line idle).
- Synchroniser:
  - rxd passes through 2 flops; all logic uses the synchronised value rxs.
- Tick generator:
  - DIV=(CLK_FREQ+BAUD*8)/(BAUD*16), integer division, minimum 1.
  - A free-running counter emits a tick every DIV clocks, giving 16 ticks per bit.
  - The counter is reset to 0 on the IDLE->START transition so the frame is phase-aligned.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: falling edge of rxs -> START, with tick_cnt=0.
  - START: at tick 7 (mid-bit):
    - rxs=1 -> IDLE (glitch rejected, nothing reported).
    - rxs=0 -> DATA, tick_cnt=0, bit_idx=0.
  - DATA: every 16 ticks, sample rxs into shift[bit_idx] (LSB first).
    - After bit 7 -> STOP.
  - STOP: at mid-bit:
    - rxs=1 -> push byte, then IDLE.
    - rxs=0 -> framing_err pulse, byte discarded, then WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then IDLE. A break condition therefore yields exactly one framing_err.
- Latency:
  - data_valid rises 1 clk after the stop-bit sample tick when the FIFO was empty.
  - Back-to-back frames with no idle gap are received without loss.
- FIFO:
  - Registered, first-word fall-through.
  - data_out always shows the head entry.
  - Pop on data_valid && data_ready.
- Boundary conditions:
  - Full + push, no pop: byte dropped, overrun pulses 1 clk, contents unchanged.
  - Full + simultaneous push and pop: both performed, no overrun, level unchanged.
  - Empty + push and no pop: level goes 0->1.
  - data_ready while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH; the extra bit in fifo_level distinguishes full from empty.
- Reset asserted mid-frame or with FIFO contents:
  - Everything returns to reset values immediately.
  - The partial frame is lost.
  - After release, the receiver waits for a new falling edge; a line already low after release is not treated as a start until it has gone high once.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP; the frame is 8E1.
  - The parity bit is sampled at mid-bit.
  - On mismatch, the byte is discarded and an extra output parity_err (1 bit, reset 0) pulses 1 clk, coincident with the stop-bit sample.
  - Framing is still checked and takes precedence: if both errors occur, only framing_err pulses.
- Undefined: no parity state, no parity_err port; the frame is 8N1.

Test Plan:
- All scenarios use CLK_FREQ=1600000, BAUD=100000 (DIV=1, 16 clk/bit).
- Single byte: send 0xA5 with data_ready=1 -> data_valid high for 1 clk with data_out=0xA5, no error pulses.
- Back-to-back with backpressure: send 0x01,0x02,0x03,0x04 with no idle gap and data_ready=0 -> fifo_level=4. Raise data_ready -> bytes pop in order 0x01..0x04, then data_valid=0.
- Overrun: FIFO full, send 0x55 -> overrun pulses once, fifo_level stays 4, head still 0x01. Then send 0x66 while popping one per clk -> 0x66 is accepted and no overrun.
- Glitch and framing:
  - rxd low for 5 clks -> no byte and no error.
  - Frame 0x3C with stop bit low, line held low for 64 clks -> exactly one framing_err, nothing pushed. Next valid frame 0x7E is received.
- Reset mid-frame: assert reset_n=0 during bit 4 of 0xF0 -> all outputs 0. After release, send 0x81 -> only 0x81 is received.
- UART_RX_PARITY_EN: send 0xA5 with parity 0 -> accepted. Send 0xA5 with parity 1 -> parity_err pulses, fifo_level unchanged.
